// File: rtl/spim_trace_pkg.sv
// Shared definitions for the spim trace buffer: FSM encoding, record field offsets and record width.
// REC_W grows by a 16-bit timestamp field when SPIM_TRACE_TIMESTAMP_EN is defined.
package spim_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

    localparam int ALU_LSB      = 0;
    localparam int INSTR_LSB    = 32;
    localparam int PC_LSB       = 64;
    localparam int PC_W         = 10;
    localparam int REGWRITE_BIT = 74;
    localparam int MEMWRITE_BIT = 75;
    localparam int ZERO_BIT     = 76;
    localparam int BRANCH_BIT   = 77;
    localparam int TS_LSB       = 78;
    localparam int TS_W         = 16;

    localparam int REC_W_BASE = 78;
    localparam int REC_W_TS   = 94;

`ifdef SPIM_TRACE_TIMESTAMP_EN
    localparam int REC_W = REC_W_TS;
`else
    localparam int REC_W = REC_W_BASE;
`endif

    function automatic logic [REC_W_BASE-1:0] pack_base(
        input logic            branch,
        input logic            zero,
        input logic            memwrite,
        input logic            regwrite,
        input logic [PC_W-1:0] pc,
        input logic [31:0]     instruction,
        input logic [31:0]     alu_result
    );
        return {branch, zero, memwrite, regwrite, pc, instruction, alu_result};
    endfunction

endpackage

// File: rtl/spim_trace_buffer_if.sv
// Record handshake between the trace buffer (master) and its consumer (slave).
interface spim_trace_buffer_if;
    import spim_trace_pkg::*;

    logic [REC_W-1:0] trace_data;
    logic             trace_valid;
    logic             trace_ready;

    modport master (output trace_data, output trace_valid, input trace_ready);
    modport slave  (input trace_data, input trace_valid, output trace_ready);

endinterface

// File: rtl/spim_trace_fifo.sv
// Synchronous FIFO with separately tracked level; a push into a full FIFO succeeds when a pop happens the same cycle.
module spim_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 78
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // Storage is never reset, so the head is forced to zero while nothing is queued.
    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/spim_trace_buffer.sv
// Triggered commit-trace capture for top_spim: FSM, window/drop counters and FIFO for draining records.
// Optional SPIM_TRACE_TIMESTAMP_EN prepends a free-running 16-bit cycle stamp to every record.
module spim_trace_buffer
    import spim_trace_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int CAPTURE_LEN = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       capture_en,
    input  logic [9:0]                 trig_pc,
    input  logic [9:0]                 pc_in,
    input  logic [31:0]                instruction_in,
    input  logic [31:0]                alu_result_in,
    input  logic                       branch_in,
    input  logic                       zero_in,
    input  logic                       memwrite_in,
    input  logic                       regwrite_in,
    spim_trace_buffer_if.master        trace,
    output logic [1:0]                 state_out,
    output logic [15:0]                drop_count,
    output logic [$clog2(DEPTH):0]     fifo_level
);
    trace_state_e     state_q;
    trace_state_e     state_d;
    logic [15:0]      win_cnt_q;
    logic [15:0]      win_cnt_d;
    logic             push_req;
    logic             pop_fire;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] rec;
    logic [REC_W-1:0] head_data;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            win_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    // The trigger cycle itself is the first attempt of the window.
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        push_req  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                win_cnt_d = '0;
                if (capture_en) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!capture_en) begin
                    state_d = ST_IDLE;
                end else if (pc_in == trig_pc) begin
                    push_req  = 1'b1;
                    win_cnt_d = 16'd1;
                    state_d   = (CAPTURE_LEN == 1) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!capture_en) begin
                    state_d = ST_IDLE;
                end else begin
                    push_req  = 1'b1;
                    win_cnt_d = win_cnt_q + 16'd1;
                    if (win_cnt_d == 16'(CAPTURE_LEN)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!capture_en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop_fire = trace.trace_valid && trace.trace_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (push_req && fifo_full && !pop_fire) begin
            drop_count <= sat_inc16(drop_count);
        end
    end

`ifdef SPIM_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_q + TS_W'(1);
    end

    assign rec = {ts_q, pack_base(branch_in, zero_in, memwrite_in, regwrite_in,
                                  pc_in, instruction_in, alu_result_in)};
`else
    assign rec = pack_base(branch_in, zero_in, memwrite_in, regwrite_in,
                           pc_in, instruction_in, alu_result_in);
`endif

    spim_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (rec),
        .pop       (pop_fire),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign trace.trace_data  = head_data;
    assign trace.trace_valid = !fifo_empty;
    assign state_out         = state_q;

endmodule

// File: tb/tb_spim_trace_buffer.sv
// Directed bench for spim_trace_buffer with a queue scoreboard of expected records.
module tb_spim_trace_buffer;
    import spim_trace_pkg::*;

    localparam int DEPTH       = 16;
    localparam int CAPTURE_LEN = 20;
    localparam int LVL_W       = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             capture_en;
    logic [9:0]       trig_pc;
    logic [9:0]       pc_in;
    logic [31:0]      instr;
    logic [31:0]      alu;
    logic             br, zr, mw, rw;
    logic [1:0]       state_out;
    logic [15:0]      drop_count;
    logic [LVL_W-1:0] fifo_level;

    spim_trace_buffer_if bif();

    spim_trace_buffer #(
        .DEPTH       (DEPTH),
        .CAPTURE_LEN (CAPTURE_LEN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .capture_en     (capture_en),
        .trig_pc        (trig_pc),
        .pc_in          (pc_in),
        .instruction_in (instr),
        .alu_result_in  (alu),
        .branch_in      (br),
        .zero_in        (zr),
        .memwrite_in    (mw),
        .regwrite_in    (rw),
        .trace          (bif),
        .state_out      (state_out),
        .drop_count     (drop_count),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int pop_count = 0;
    int pops_before;

    logic [REC_W-1:0] mq[$];
    logic [1:0]       mstate = 2'd0;
    int               mcnt   = 0;
    logic [15:0]      mdrops = 16'd0;
    logic [15:0]      mts    = 16'd0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] make_rec();
        logic [77:0] b;
        b = {br, zr, mw, rw, pc_in, instr, alu};
`ifdef SPIM_TRACE_TIMESTAMP_EN
        return {mts, b};
`else
        return b;
`endif
    endfunction

    // One clock: predict pop/push from the reference model, then check outputs 1 time unit after the edge.
    task automatic tick();
        logic [REC_W-1:0] r;
        logic [REC_W-1:0] exp;
        logic             pop;
        logic             push_req;
        logic [1:0]       nstate;
        instr = $urandom;
        alu   = $urandom;
        {br, zr, mw, rw} = 4'($urandom);
        r   = make_rec();
        pop = reset && (mq.size() != 0) && bif.trace_ready;
        if (pop) begin
            exp = mq.pop_front();
            pop_count++;
            chk("pop_data", bif.trace_data, exp);
        end
        push_req = 1'b0;
        nstate   = mstate;
        case (mstate)
            2'd0: if (capture_en) nstate = 2'd1;
            2'd1: begin
                if (!capture_en) nstate = 2'd0;
                else if (pc_in == trig_pc) begin
                    push_req = 1'b1;
                    mcnt     = 1;
                    nstate   = (mcnt == CAPTURE_LEN) ? 2'd3 : 2'd2;
                end
            end
            2'd2: begin
                if (!capture_en) nstate = 2'd0;
                else begin
                    push_req = 1'b1;
                    mcnt++;
                    if (mcnt == CAPTURE_LEN) nstate = 2'd3;
                end
            end
            default: if (!capture_en) nstate = 2'd0;
        endcase
        if (push_req) begin
            if (mq.size() < DEPTH) mq.push_back(r);
            else if (mdrops != 16'hFFFF) mdrops++;
        end
        mstate = nstate;
        mts++;
        if (!reset) begin
            mq.delete();
            mstate = 2'd0;
            mcnt   = 0;
            mdrops = 16'd0;
            mts    = 16'd0;
        end
        @(posedge clk);
        #1;
        chk("state", state_out, mstate);
        chk("level", fifo_level, mq.size());
        chk("drops", drop_count, mdrops);
        chk("valid", bif.trace_valid, mq.size() != 0);
        if (mq.size() != 0) chk("head", bif.trace_data, mq[0]);
    endtask

    task automatic run(input int n, input logic ce, input logic rdy, input int pc0);
        for (int i = 0; i < n; i++) begin
            capture_en      = ce;
            bif.trace_ready = rdy;
            pc_in           = 10'(pc0 + 4 * i);
            tick();
        end
    endtask

    initial begin
        reset           = 1'b0;
        capture_en      = 1'b0;
        trig_pc         = 10'h010;
        pc_in           = '0;
        bif.trace_ready = 1'b0;
        @(negedge clk);

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            capture_en      = 1'($urandom);
            bif.trace_ready = 1'($urandom);
            pc_in           = 10'($urandom);
            tick();
        end
        chk("rst_state", state_out, 2'd0);
        chk("rst_valid", bif.trace_valid, 1'b0);
        chk("rst_drops", drop_count, 16'd0);
        chk("rst_level", fifo_level, 5'd0);
        chk("rst_data", bif.trace_data, '0);
        reset   = 1'b1;
        trig_pc = 10'h010;

        // Trigger and full window with consumer always ready
        run(1, 1'b1, 1'b1, 0);
        chk("armed", state_out, 2'd1);
        pops_before = pop_count;
        run(4, 1'b1, 1'b1, 4);
        chk("capture", state_out, 2'd2);
        chk("first_valid", bif.trace_valid, 1'b1);
        chk("first_pc", bif.trace_data[PC_LSB +: PC_W], 10'h010);
        run(21, 1'b1, 1'b1, 'h14);
        chk("window_pops", pop_count - pops_before, CAPTURE_LEN);
        chk("window_done", state_out, 2'd3);
        chk("window_drops", drop_count, 16'd0);

        // Overflow with consumer stalled, then drain in order
        run(1, 1'b0, 1'b0, 0);
        run(26, 1'b1, 1'b0, 0);
        chk("ovf_level", fifo_level, 5'd16);
        chk("ovf_drops", drop_count, 16'd4);
        pops_before = pop_count;
        run(17, 1'b0, 1'b1, 0);
        chk("ovf_drained", pop_count - pops_before, 16);
        chk("ovf_empty", fifo_level, 5'd0);

        // Full FIFO with simultaneous pop: no further drops
        run(20, 1'b1, 1'b0, 0);
        chk("full_level", fifo_level, 5'd16);
        run(4, 1'b1, 1'b1, 'h50);
        chk("fullpop_level", fifo_level, 5'd16);
        chk("fullpop_drops", drop_count, 16'd4);
        chk("fullpop_state", state_out, 2'd3);
        run(20, 1'b0, 1'b1, 0);
        chk("fullpop_empty", fifo_level, 5'd0);

        // Abort after three captured records
        run(7, 1'b1, 1'b0, 0);
        chk("abort_pre", state_out, 2'd2);
        run(1, 1'b0, 1'b0, 'h1C);
        chk("abort_state", state_out, 2'd0);
        chk("abort_level", fifo_level, 5'd3);
        pops_before = pop_count;
        run(5, 1'b0, 1'b1, 0);
        chk("abort_drained", pop_count - pops_before, 3);

        // Reset in the middle of a window
        run(8, 1'b1, 1'b0, 0);
        chk("midrst_pre", fifo_level, 5'd4);
        reset      = 1'b0;
        capture_en = 1'b1;
        tick();
        chk("midrst_level", fifo_level, 5'd0);
        chk("midrst_state", state_out, 2'd0);
        chk("midrst_valid", bif.trace_valid, 1'b0);
        reset = 1'b1;
        run(3, 1'b0, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
